// File: rtl/seq_mult_hs.sv
// -----------------------------------------------------------------------------
// seq_mult_hs -- parametrised multi-cycle shift-add multiplier with handshakes.
//
// Takes one operand pair at a time on a valid/ready input port. It multiplies
// the operand magnitudes with a shift-add loop, applies the sign in one fix-up
// cycle, and holds the product on a valid/ready output port until the consumer
// takes it. Only one operation is in flight at a time.
//
// Build option:
//   MULT_RADIX4_EN  When defined, the loop retires 2 multiplier bits per
//                   cycle, which takes WIDTH/2 cycles. WIDTH must then be even.
//                   When undefined, the loop retires 1 bit per cycle, which
//                   takes WIDTH cycles. Both builds give identical products.
//
// Parameters:
//   WIDTH      operand width in bits (>= 4)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   flush      synchronous abort to IDLE; the result register keeps its value
//   in_valid   operands/mode valid
//   in_ready   high only in IDLE
//   is_signed  1: a and b are two's complement; sampled at accept
//   a, b       multiplicand, multiplier
//   out_valid  product valid; held until out_ready
//   out_ready  consumer accepts the product
//   result     2*WIDTH-bit product
//   busy       high in CALC or FIX
// -----------------------------------------------------------------------------
module seq_mult_hs #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
`ifdef MULT_RADIX4_EN
    localparam int BITS_PER_STEP = 2;
`else
    localparam int BITS_PER_STEP = 1;
`endif
    localparam int CALC_CYCLES = WIDTH / BITS_PER_STEP;
    localparam int CW          = $clog2(CALC_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CALC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   mcand_q, mcand_d;     // multiplicand magnitude, shifted left each step
    logic [WIDTH-1:0] mplier_q, mplier_d;  // multiplier magnitude, shifted right each step
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   result_q, result_d;
    logic            neg_q, neg_d;
    logic            out_valid_q, out_valid_d;
`ifdef MULT_RADIX4_EN
    logic [PW-1:0]   mcand3_q, mcand3_d;   // 3x multiplicand, shifted along with mcand
    logic [PW-1:0]   partial;
`endif

    logic            out_fire;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign out_fire = out_valid_q && out_ready;

    // The magnitude of the most negative value, 2^(WIDTH-1), still fits in an
    // unsigned WIDTH-bit field, so negating in WIDTH bits cannot overflow.
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (in_valid)          state_d = S_CALC;
                S_CALC:  if (cnt_q == LAST_CNT) state_d = S_FIX;
                S_FIX:                          state_d = S_DONE;
                S_DONE:  if (out_fire)          state_d = S_IDLE;
                default:                        state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        in_ready = (state_q == S_IDLE);
        busy     = (state_q == S_CALC) || (state_q == S_FIX);
    end

    // out_valid is registered on entry into DONE. It therefore rises one edge
    // after the FIX cycle writes the result, and the result is already stable
    // when out_valid rises.
    always_comb begin
        out_valid_d = 1'b0;
        if (!flush && state_q == S_DONE) begin
            out_valid_d = !out_fire;
        end
    end

    // ---------------- datapath ----------------
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        neg_d    = neg_q;
`ifdef MULT_RADIX4_EN
        mcand3_d = mcand3_q;
        partial  = '0;
`endif
        if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_d  = PW'(a_mag);
                        mplier_d = b_mag;
                        acc_d    = '0;
                        cnt_d    = '0;
                        neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULT_RADIX4_EN
                        mcand3_d = PW'(a_mag) + (PW'(a_mag) << 1);
`endif
                    end
                end
                S_CALC: begin
`ifdef MULT_RADIX4_EN
                    case (mplier_q[1:0])
                        2'd1:    partial = mcand_q;
                        2'd2:    partial = mcand_q << 1;
                        2'd3:    partial = mcand3_q;
                        default: partial = '0;
                    endcase
                    acc_d    = acc_q + partial;
                    mcand_d  = mcand_q << 2;
                    mcand3_d = mcand3_q << 2;
                    mplier_d = mplier_q >> 2;
`else
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
`endif
                    cnt_d = cnt_q + CW'(1);
                end
                S_FIX: begin
                    // A zero product negates to zero, so no special case is needed.
                    result_d = neg_q ? -acc_q : acc_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MULT_RADIX4_EN
            mcand3_q    <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
`ifdef MULT_RADIX4_EN
            mcand3_q    <= mcand3_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench for seq_mult_hs. Expected products come from plain 64-bit
// signed/unsigned arithmetic on the operands.
module tb_seq_mult_hs;
    localparam int W = 32;
`ifdef MULT_RADIX4_EN
    localparam int LAT = W / 2 + 2;
`else
    localparam int LAT = W + 2;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           is_signed = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready, out_valid, busy;
    logic [2*W-1:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mult_hs #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    function automatic logic [63:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
        logic [63:0] ux, uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'b0, x};
        uy = {32'b0, y};
        return ux * uy;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait from the negedge after an accept edge until out_valid rises.
    // Returns the number of edges since the accept edge.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int n;
        logic [63:0] e;
        e = model(s, x, y);
        @(negedge clk);
        check({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1; is_signed = s; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs to confirm the operands were captured at accept.
        in_valid = 1'b0; is_signed = 1'($urandom); a = $urandom; b = $urandom;
        check({tag, "_busy"}, busy, 1);
        wait_valid(n);
        check({tag, "_lat"}, n, LAT);
        check({tag, "_res"}, result, e);
        handshake(tag);
    endtask

    initial begin
        int n, ovs;
        logic [63:0] e, last;
        logic s;
        logic [W-1:0] x, y;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        reset = 1'b1;

        // Directed products
        run_op(1, 32'd553524, 32'd840, "t2");
        run_op(1, -32'sd259, -32'sd259, "neg_neg");
        run_op(1, -32'sd1199060305, 32'd1, "neg_one");
        run_op(1, 32'd5, 32'd0, "zero");
        run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, "umax");
        run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, "sm1");
        run_op(1, 32'h80000000, 32'h80000000, "smin");
        run_op(1, 32'h80000000, 32'd0, "smin_zero");

        // Random products
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom);
            x = $urandom;
            y = $urandom;
            run_op(s, x, y, "rnd");
        end

        // Output back-pressure while the next operands are held valid
        e = model(0, 32'd123456, 32'd789);
        @(negedge clk);
        in_valid = 1'b1; is_signed = 1'b0; a = 32'd123456; b = 32'd789;
        @(posedge clk);
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h00001234; is_signed = 1'b1;
        wait_valid(n);
        check("bp_lat", n, LAT);
        for (int i = 0; i < 10; i++) begin
            check("bp_res", result, e);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        handshake("bp");
        // in_valid is still high, so this edge accepts the second operand pair.
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp2_busy", busy, 1);
        wait_valid(n);
        last = model(1, 32'hDEADBEEF, 32'h00001234);
        check("bp2_lat", n, LAT);
        check("bp2_res", result, last);
        handshake("bp2");

        // Flush during CALC
        @(negedge clk);
        in_valid = 1'b1; is_signed = 1'b1; a = 32'd553524; b = 32'd840;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("fl_busy", busy, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_out_valid", out_valid, 0);
        check("fl_result_kept", result, last);
        ovs = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (out_valid) ovs++;
        end
        check("fl_no_valid", ovs, 0);

        // Flush has priority over an accept in IDLE
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("fl_idle_busy", busy, 0);
        check("fl_idle_ready", in_ready, 1);

        // Asynchronous reset during CALC
        @(negedge clk);
        in_valid = 1'b1; is_signed = 1'b0; a = 32'd77; b = 32'd99;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_busy", busy, 0);
        check("ar_result", result, 0);
        @(negedge clk);
        reset = 1'b1;
        run_op(1, 32'd553524, 32'd840, "ar_resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
